// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU; remainder on hi_out, quotient on lo_out.
// Optional DIV_UNIT_ZERO_FAST_EN: a zero divisor skips the iteration phase and finishes in one cycle.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        annul,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t      state_q, state_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic [31:0] raw_q, raw_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        zero_q, zero_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [31:0] absDividend;
    logic [31:0] absDivisor;
    logic [33:0] shifted;
    logic [33:0] diff;
    logic [31:0] quoFix;
    logic [31:0] remFix;
    logic        accept;

    // quo_q starts as the conditioned dividend and fills with quotient bits as it shifts out
    assign absDividend = (signed_div && dividend[31]) ? (~dividend + 32'd1) : dividend;
    assign absDivisor  = (signed_div && divisor[31])  ? (~divisor + 32'd1)  : divisor;
    assign shifted     = {rem_q, quo_q[31]};
    assign diff        = shifted - {2'b00, dvsr_q};
    assign quoFix      = qneg_q ? (~quo_q + 32'd1) : quo_q;
    assign remFix      = rneg_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
    // The done cycle still counts as the tail of the previous operation
    assign accept      = start && !annul && !done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            raw_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            raw_q   <= raw_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        raw_d   = raw_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    quo_d  = absDividend;
                    dvsr_d = absDivisor;
                    raw_d  = dividend;
                    qneg_d = signed_div & (dividend[31] ^ divisor[31]);
                    rneg_d = signed_div & dividend[31];
                    zero_d = (divisor == 32'd0);
                    rem_d  = '0;
                    cnt_d  = '0;
`ifdef DIV_UNIT_ZERO_FAST_EN
                    state_d = (divisor == 32'd0) ? FIN : RUN;
`else
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                if (annul) begin
                    state_d = IDLE;
                end else begin
                    if (!diff[33]) begin
                        rem_d = diff[32:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = shifted[32:0];
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                if (!annul) begin
                    done_d = 1'b1;
                    if (zero_q) begin
                        lo_d = 32'hFFFF_FFFF;
                        hi_d = raw_q;
                    end else begin
                        lo_d = quoFix;
                        hi_d = remFix;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule
